plab4_net_router_tdm_out_sched: RTL and testbench

//  Output-port scheduler for one router output: shares the output among 3 input ports, one multi-flit packet at a time.
//  Two security domains (0/1) get fixed alternating time slots, so domain-1 traffic never alters domain-0 grant timing.

---
 rtl/plab4_net_router_tdm_out_sched_if.sv | 25 ++
 rtl/plab4_net_router_tdm_out_sched.sv | 103 ++++++++++
 tb/tb_plab4_net_router_tdm_out_sched.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/plab4_net_router_tdm_out_sched_if.sv
// Handshake bundle between the router input queues and one output-port TDM scheduler.
// The master side owns the queue heads and downstream ready; the slave side is the scheduler.
interface plab4_net_router_tdm_out_sched_if #(
  parameter int CW = 3
);
  logic [2:0]    in_val;
  logic [2:0]    in_domain;
  logic [2:0]    in_tail;
  logic [2:0]    grants;
  logic          out_val;
  logic          out_rdy;
  logic [1:0]    xbar_sel;
  logic          out_domain;
  logic [CW-1:0] slot_cnt;

  modport master (
    output in_val, in_domain, in_tail, out_rdy,
    input  grants, out_val, xbar_sel, out_domain, slot_cnt
  );

  modport slave (
    input  in_val, in_domain, in_tail, out_rdy,
    output grants, out_val, xbar_sel, out_domain, slot_cnt
  );
endinterface

// File: rtl/plab4_net_router_tdm_out_sched.sv
// TDM output scheduler: two security domains alternate fixed slots; each domain keeps its own
// round-robin pointer and packet lock so one domain's traffic cannot shift the other's timing.
module plab4_net_router_tdm_out_sched #(
  parameter int p_slot_len  = 8,
  parameter int p_max_flits = 4,
  localparam int CW         = $clog2(p_slot_len)
) (
  input  logic                             clk,
  input  logic                             reset,
  plab4_net_router_tdm_out_sched_if.slave  bus
);

  localparam logic [CW-1:0] SLOT_LAST  = CW'(p_slot_len - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(p_slot_len - p_max_flits);

  logic [CW-1:0]   slot_cnt_q, slot_cnt_d;
  logic            dom_q, dom_d;
  logic [1:0][1:0] rr_ptr_q, rr_ptr_d;
  logic [1:0]      lock_v_q, lock_v_d;
  logic [1:0][1:0] lock_port_q, lock_port_d;

  logic [2:0] elig;
  logic [2:0] grant_c;
  logic [1:0] sel_c;
  logic [1:0] lock_p;
  logic [1:0] cand;
  logic       found;
  logic       xfer;

  function automatic logic [1:0] wrap3(input logic [2:0] v);
    return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
  endfunction

  assign elig   = bus.in_val & (dom_q ? bus.in_domain : ~bus.in_domain);
  assign lock_p = lock_port_q[dom_q];

  // Grant is combinational; a held lock bypasses the guard band so a suspended packet resumes at cnt 0.
  always_comb begin
    grant_c = '0;
    sel_c   = '0;
    found   = 1'b0;
    cand    = '0;
    if (reset) begin
      if (lock_v_q[dom_q]) begin
        if (elig[lock_p]) begin
          grant_c[lock_p] = 1'b1;
          sel_c           = lock_p;
        end
      end else if (slot_cnt_q <= GUARD_LAST) begin
        for (int k = 0; k < 3; k++) begin
          cand = wrap3({1'b0, rr_ptr_q[dom_q]} + 3'(k));
          if (!found && elig[cand]) begin
            found         = 1'b1;
            grant_c[cand] = 1'b1;
            sel_c         = cand;
          end
        end
      end
    end
  end

  assign xfer = (|grant_c) & bus.out_rdy;

  always_comb begin
    slot_cnt_d  = (slot_cnt_q == SLOT_LAST) ? '0 : slot_cnt_q + 1'b1;
    dom_d       = (slot_cnt_q == SLOT_LAST) ? ~dom_q : dom_q;
    rr_ptr_d    = rr_ptr_q;
    lock_v_d    = lock_v_q;
    lock_port_d = lock_port_q;
    if (xfer) begin
      if (bus.in_tail[sel_c]) begin
        lock_v_d[dom_q] = 1'b0;
        rr_ptr_d[dom_q] = wrap3({1'b0, sel_c} + 3'd1);
      end else begin
        lock_v_d[dom_q]    = 1'b1;
        lock_port_d[dom_q] = sel_c;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_cnt_q  <= '0;
      dom_q       <= 1'b0;
      rr_ptr_q    <= '0;
      lock_v_q    <= '0;
      lock_port_q <= '0;
    end else begin
      slot_cnt_q  <= slot_cnt_d;
      dom_q       <= dom_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_v_q    <= lock_v_d;
      lock_port_q <= lock_port_d;
    end
  end

  assign bus.grants     = grant_c;
  assign bus.out_val    = |grant_c;
  assign bus.xbar_sel   = sel_c;
  assign bus.out_domain = dom_q;
  assign bus.slot_cnt   = slot_cnt_q;

endmodule

// File: tb/tb_plab4_net_router_tdm_out_sched.sv
// Bench for the TDM output scheduler: packet-queue reference model plus directed and random scenarios.
module tb_plab4_net_router_tdm_out_sched;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  plab4_net_router_tdm_out_sched_if #(.CW(3)) bus ();

  plab4_net_router_tdm_out_sched #(.p_slot_len(8), .p_max_flits(4)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Upstream queues: remaining flits of each queued packet and its domain.
  int   qf[3][$];
  bit   qd[3][$];
  int   t;
  bit   own_v[2];
  int   own_p[2];
  int   last_p[2];
  logic [2:0] prev_g, exp_g;
  bit   prev_rdy;

  function automatic int gidx(input logic [2:0] g);
    return g[1] ? 1 : (g[2] ? 2 : 0);
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 3; p++) begin
      qf[p].delete();
      qd[p].delete();
    end
    t = 0;
    own_v[0] = 0; own_v[1] = 0;
    own_p[0] = 0; own_p[1] = 0;
    last_p[0] = 2; last_p[1] = 2;
    prev_g = '0;
    prev_rdy = 0;
  endtask

  function automatic logic [2:0] predict();
    int d;
    logic [2:0] el;
    logic [2:0] g;
    d = (t / 8) % 2;
    g = '0;
    for (int p = 0; p < 3; p++)
      el[p] = (qf[p].size() > 0) && (int'(qd[p][0]) == d);
    if (own_v[d]) begin
      if (el[own_p[d]]) g[own_p[d]] = 1'b1;
    end else if ((t % 8) <= 4) begin
      for (int k = 1; k <= 3; k++) begin
        if (g == 3'b000 && el[(last_p[d] + k) % 3]) g[(last_p[d] + k) % 3] = 1'b1;
      end
    end
    return g;
  endfunction

  task automatic commit();
    int p, d;
    if (prev_rdy && prev_g != 3'b000) begin
      p = gidx(prev_g);
      d = (t / 8) % 2;
      qf[p][0] = qf[p][0] - 1;
      if (qf[p][0] == 0) begin
        void'(qf[p].pop_front());
        void'(qd[p].pop_front());
        own_v[d]  = 0;
        last_p[d] = p;
      end else begin
        own_v[d] = 1;
        own_p[d] = p;
      end
    end
    t++;
  endtask

  task automatic enq(input int p, input int n, input bit dom);
    qf[p].push_back(n);
    qd[p].push_back(dom);
  endtask

  task automatic advance(input bit rdy);
    commit();
    @(posedge clk);
    #1;
    for (int p = 0; p < 3; p++) begin
      bus.in_val[p]    = qf[p].size() > 0;
      bus.in_domain[p] = (qf[p].size() > 0) ? qd[p][0] : 1'b0;
      bus.in_tail[p]   = (qf[p].size() > 0) ? (qf[p][0] == 1) : 1'b0;
    end
    bus.out_rdy = rdy;
    @(negedge clk);
    exp_g    = predict();
    prev_g   = exp_g;
    prev_rdy = rdy;
  endtask

  task automatic run_to(input int target);
    while (t < target - 1) advance(1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.in_val = '0; bus.in_domain = '0; bus.in_tail = '0; bus.out_rdy = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.in_val = 3'b111; bus.in_domain = 3'b000; bus.in_tail = 3'b111; bus.out_rdy = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (bus.grants !== 3'b000) begin bad++; $display("FAIL reset_grants got=%b exp=000", bus.grants); end
    total++; if (bus.out_val !== 1'b0) begin bad++; $display("FAIL reset_out_val got=%b exp=0", bus.out_val); end
    total++; if (bus.xbar_sel !== 2'd0) begin bad++; $display("FAIL reset_xbar_sel got=%0d exp=0", bus.xbar_sel); end
    total++; if (bus.out_domain !== 1'b0) begin bad++; $display("FAIL reset_out_domain got=%b exp=0", bus.out_domain); end
    total++; if (bus.slot_cnt !== 3'd0) begin bad++; $display("FAIL reset_slot_cnt got=%0d exp=0", bus.slot_cnt); end
    bus.in_val = '0; bus.out_rdy = 1'b0;
    model_reset();
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      advance(1'b0);
      total++;
      if (bus.slot_cnt !== 3'((i + 1) % 8) || bus.out_domain !== (i == 7)) begin
        bad++;
        $display("FAIL slot_timer cyc=%0d got cnt=%0d dom=%b exp cnt=%0d dom=%b",
                 i, bus.slot_cnt, bus.out_domain, (i + 1) % 8, (i == 7));
      end
    end
  endtask

  task automatic test_rr_dom0();
    logic [2:0] tbl[4];
    tbl[0] = 3'b001; tbl[1] = 3'b010; tbl[2] = 3'b100; tbl[3] = 3'b001;
    do_reset();
    enq(0, 1, 0); enq(0, 1, 0); enq(1, 1, 0); enq(2, 1, 0);
    for (int i = 0; i < 4; i++) begin
      advance(1'b1);
      total++;
      if (bus.grants !== tbl[i] || bus.xbar_sel !== 2'(gidx(tbl[i])) || bus.out_val !== 1'b1) begin
        bad++;
        $display("FAIL rr_dom0 cyc=%0d got g=%b sel=%0d val=%b exp g=%b", i, bus.grants, bus.xbar_sel,
                 bus.out_val, tbl[i]);
      end
    end
  endtask

  task automatic test_lock();
    logic [2:0] tbl[4];
    tbl[0] = 3'b010; tbl[1] = 3'b010; tbl[2] = 3'b010; tbl[3] = 3'b001;
    do_reset();
    enq(0, 1, 0);
    advance(1'b1);
    total++; if (bus.grants !== 3'b001) begin bad++; $display("FAIL lock_prime got=%b exp=001", bus.grants); end
    run_to(16);
    enq(1, 3, 0); enq(0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      advance(1'b1);
      total++;
      if (bus.grants !== tbl[i] || bus.grants !== exp_g) begin
        bad++;
        $display("FAIL lock cyc=%0d got=%b exp=%b model=%b", i, bus.grants, tbl[i], exp_g);
      end
    end
  endtask

  task automatic test_guard();
    logic [2:0] e;
    do_reset();
    run_to(5);
    enq(0, 4, 0);
    while (t < 19) begin
      advance(1'b1);
      e = (t >= 16) ? 3'b001 : 3'b000;
      total++;
      if (bus.grants !== e || bus.grants !== exp_g) begin
        bad++;
        $display("FAIL guard t=%0d cnt=%0d got=%b exp=%b model=%b", t, bus.slot_cnt, bus.grants, e, exp_g);
      end
    end
  endtask

  task automatic test_suspend();
    logic [2:0] e;
    do_reset();
    run_to(4);
    enq(0, 4, 0); enq(1, 1, 0);
    while (t < 19) begin
      advance(!(t + 1 == 5 || t + 1 == 6));
      if (t <= 7 || t == 16 || t == 17) e = 3'b001;
      else if (t == 18)                 e = 3'b010;
      else                              e = 3'b000;
      total++;
      if (bus.grants !== e || bus.grants !== exp_g) begin
        bad++;
        $display("FAIL suspend t=%0d got=%b exp=%b model=%b", t, bus.grants, e, exp_g);
      end
    end
  endtask

  task automatic test_isolation();
    bit g0[2][40];
    for (int run = 0; run < 2; run++) begin
      do_reset();
      enq(0, 3, 0); enq(0, 1, 0); enq(0, 4, 0); enq(0, 2, 0); enq(0, 2, 0); enq(0, 1, 0);
      for (int i = 0; i < 40; i++) begin
        if (run == 1 && qf[2].size() == 0) enq(2, 1, 1);
        advance(1'b1);
        g0[run][i] = bus.grants[0];
        total++;
        if (bus.grants !== exp_g || (bus.grants[0] && bus.out_domain)) begin
          bad++;
          $display("FAIL isolation run=%0d cyc=%0d got=%b exp=%b dom=%b", run, i, bus.grants, exp_g,
                   bus.out_domain);
        end
      end
    end
    for (int i = 0; i < 40; i++) begin
      total++;
      if (g0[1][i] !== g0[0][i]) begin
        bad++;
        $display("FAIL isolation_timing cyc=%0d busy=%b idle=%b", i, g0[1][i], g0[0][i]);
      end
    end
  endtask

  task automatic test_random();
    int p;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        p = $urandom_range(0, 2);
        if (qf[p].size() < 3) enq(p, $urandom_range(1, 4), 1'($urandom_range(0, 1)));
      end
      advance($urandom_range(0, 3) != 0);
      total++;
      if (bus.grants !== exp_g || bus.out_val !== (|exp_g) || bus.xbar_sel !== 2'(gidx(exp_g)) ||
          bus.slot_cnt !== 3'(t % 8) || bus.out_domain !== 1'((t / 8) % 2)) begin
        bad++;
        $display("FAIL random t=%0d got g=%b val=%b sel=%0d cnt=%0d dom=%b exp g=%b cnt=%0d dom=%0d",
                 t, bus.grants, bus.out_val, bus.xbar_sel, bus.slot_cnt, bus.out_domain, exp_g,
                 t % 8, (t / 8) % 2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rr_dom0();
    test_lock();
    test_guard();
    test_suspend();
    test_isolation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
